vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock: hsync/vsync, h_display/v_display, pixel coordinates and frame/line markers. It also contains a small built-in test-pattern source that produces 2-bit R/G/B values for the downstream colour mux. The mux's select input is this block's h_display AND v_display.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
CNT_W, 10, counter/coordinate width

Ports:
clk  input  1  pixel clock, 25 MHz
reset_n  input  1  asynchronous active-low reset
pattern_sel  input  2  test pattern: 0 black, 1 colour bars, 2 checkerboard, 3 grey ramp
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
h_display  output  1  horizontal active region
v_display  output  1  vertical active region
pixel_x  output  CNT_W  current horizontal count
pixel_y  output  CNT_W  current vertical count
line_start  output  1  one-cycle pulse at pixel_x = 0
frame_start  output  1  one-cycle pulse at pixel_x = 0, pixel_y = 0
R_out, G_out, B_out  output  2 each  pattern colour, to the mux R_in/G_in/B_in

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low. All outputs are registered and update on the same clk edge, with zero relative skew.
- Reset values, held while reset_n = 0:
  - pixel_x = 0, pixel_y = 0
  - hsync = vsync = !SYNC_POL (inactive)
  - h_display = v_display = 0
  - line_start = frame_start = 0
  - R/G/B_out = 0
  - latched pattern = 0
- Start-up: an internal run flag clears on reset. The first rising edge after reset_n deassertion presents position (0,0) with fully decoded outputs (frame_start = 1, line_start = 1, displays = 1). pattern_sel is latched on that same edge.
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800; V_TOTAL = 525.
- Counters:
  - pixel_x increments every cycle and wraps H_TOTAL-1 -> 0.
  - pixel_y increments only when pixel_x wraps, and wraps V_TOTAL-1 -> 0 in the same cycle pixel_x wraps.
- Decodes, on presented values:
  - h_display = (pixel_x < H_ACTIVE)
  - v_display = (pixel_y < V_ACTIVE)
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491)
  - vsync transitions are aligned with pixel_x = 0.
- Pattern latch: pattern_sel is sampled only on cycles presenting frame_start, so there is no mid-frame change.
- Pattern outputs (registered, aligned with pixel_x/pixel_y):
  - Outside h_display && v_display: R/G/B_out = 0.
  - 0 black: all 0.
  - 1 colour bars: 8 bars of H_ACTIVE/8 = 80 px. Bar index idx is 0..7, from a bar counter that resets at line start and increments after every 80th active pixel; no divider. R = idx[2]?3:0, G = idx[1]?3:0, B = idx[0]?3:0.
  - 2 checkerboard: all channels = (pixel_x[5] ^ pixel_y[5]) ? 3 : 0.
  - 3 grey ramp: all channels = band, where band 0..3 advances every V_ACTIVE/4 = 120 lines via a band counter reset at frame start.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). Restart follows the start-up rule above.

Test Plan:
- Reset: hold reset_n = 0 for 10 cycles -> hsync = vsync = 1, displays = 0, pixel_x = pixel_y = 0, RGB = 0. Release -> next edge gives frame_start = 1, pixel (0,0), h_display = v_display = 1.
- Horizontal timing: hsync low for exactly 96 cycles starting at pixel_x = 656; h_display high for 640 cycles; line period 800 cycles; line_start every 800 cycles.
- Vertical timing: frame_start period = 420000 cycles; vsync low for 1600 cycles starting when pixel_y = 490, pixel_x = 0; v_display low for lines 480..524.
- Colour bars (pattern_sel = 1) on line 0:
  - x = 79 -> (0,0,0)
  - x = 80 -> (0,0,3)
  - x = 320 -> (3,0,0)
  - x = 639 -> (3,3,3)
  - x = 640 -> (0,0,0)
- Checkerboard and ramp:
  - pattern_sel = 2: (31,0) -> 0; (32,0) -> 3; (32,32) -> 0.
  - pattern_sel = 3: y = 119 -> 0; y = 120 -> 1; y = 479 -> 3.
- Pattern latch and mid-frame reset:
  - Change pattern_sel 1 -> 2 at y = 100: output stays bars until the next frame_start, then checkerboard.
  - Pulse reset_n low at y = 300 -> immediate reset values, clean restart at (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with registered sync/display decodes and a built-in test-pattern source.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       pattern_sel,
  output logic             hsync,
  output logic             vsync,
  output logic             h_display,
  output logic             v_display,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [1:0]       R_out,
  output logic [1:0]       G_out,
  output logic [1:0]       B_out
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [CNT_W-1:0] BAND_LAST = CNT_W'(V_ACTIVE / 4 - 1);

  logic             run_q, wrap;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, bcnt_q, bcnt_d, lcnt_q, lcnt_d;
  logic [2:0]       bar_q, bar_d;
  logic [1:0]       band_q, band_d, pat_q, pat_d, chk;
  logic             hs_q, hs_d, vs_q, vs_d, hd_q, hd_d, vd_q, vd_d, ls_q, ls_d, fs_q, fs_d;
  logic [5:0]       rgb_q, rgb_d;

  // Everything is decoded from the next position so all outputs land on the same edge.
  always_comb begin
    wrap   = x_q == H_LAST;
    x_d    = (!run_q || wrap) ? '0 : x_q + ONE;
    y_d    = !run_q ? '0 : !wrap ? y_q : (y_q == V_LAST) ? '0 : y_q + ONE;
    hd_d   = x_d < H_ACT;
    vd_d   = y_d < V_ACT;
    hs_d   = (x_d >= HS_BEG && x_d < HS_END) ? SYNC_POL : !SYNC_POL;
    vs_d   = (y_d >= VS_BEG && y_d < VS_END) ? SYNC_POL : !SYNC_POL;
    ls_d   = x_d == '0;
    fs_d   = ls_d && y_d == '0;
    bcnt_d = (ls_d || bcnt_q == BAR_LAST) ? '0 : bcnt_q + ONE;
    bar_d  = ls_d ? '0 : (bcnt_q == BAR_LAST) ? bar_q + 3'd1 : bar_q;
    lcnt_d = !ls_d ? lcnt_q : (fs_d || lcnt_q == BAND_LAST) ? '0 : lcnt_q + ONE;
    band_d = !ls_d ? band_q : fs_d ? '0 : (lcnt_q == BAND_LAST) ? band_q + 2'd1 : band_q;
    pat_d  = fs_d ? pattern_sel : pat_q;
    chk    = {2{x_d[5] ^ y_d[5]}};
    rgb_d  = !(hd_d && vd_d) ? '0 :
             (pat_d == 2'd1) ? {{2{bar_d[2]}}, {2{bar_d[1]}}, {2{bar_d[0]}}} :
             (pat_d == 2'd2) ? {3{chk}} :
             (pat_d == 2'd3) ? {3{band_d}} : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      bcnt_q <= '0;
      lcnt_q <= '0;
      bar_q  <= '0;
      band_q <= '0;
      pat_q  <= '0;
      hs_q   <= !SYNC_POL;
      vs_q   <= !SYNC_POL;
      hd_q   <= 1'b0;
      vd_q   <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      rgb_q  <= '0;
    end else begin
      run_q  <= 1'b1;
      x_q    <= x_d;
      y_q    <= y_d;
      bcnt_q <= bcnt_d;
      lcnt_q <= lcnt_d;
      bar_q  <= bar_d;
      band_q <= band_d;
      pat_q  <= pat_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      hd_q   <= hd_d;
      vd_q   <= vd_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      rgb_q  <= rgb_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign h_display   = hd_q;
  assign v_display   = vd_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign R_out       = rgb_q[5:4];
  assign G_out       = rgb_q[3:2];
  assign B_out       = rgb_q[1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a full-size 640x480 instance and a shrunken instance for frame-level behaviour.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  int tests = 0;
  int errors = 0;

  logic fhs, fvs, fhd, fvd, fls, ffs, shs, svs, shd, svd, sls, sfs;
  logic [9:0] fx, fy, sx, sy;
  logic [1:0] fr, fg, fb, sr, sg, sb;

  always #5 clk = ~clk;

  vga_timing_gen u_full (
    .clk(clk), .reset_n(reset_n), .pattern_sel(pattern_sel),
    .hsync(fhs), .vsync(fvs), .h_display(fhd), .v_display(fvd),
    .pixel_x(fx), .pixel_y(fy), .line_start(fls), .frame_start(ffs),
    .R_out(fr), .G_out(fg), .B_out(fb)
  );

  // 24 x 13 raster: bars are 2 px wide, ramp bands 2 lines tall, vsync on lines 9..10.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .pattern_sel(pattern_sel),
    .hsync(shs), .vsync(svs), .h_display(shd), .v_display(svd),
    .pixel_x(sx), .pixel_y(sy), .line_start(sls), .frame_start(sfs),
    .R_out(sr), .G_out(sg), .B_out(sb)
  );

  typedef struct {
    bit         s;
    logic [1:0] pat;
    int         x;
    int         y;
    logic [5:0] rgb;
    string      name;
  } vec_t;

  vec_t v[14];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cx(input bit s);
    return s ? int'(sx) : int'(fx);
  endfunction

  function automatic int cy(input bit s);
    return s ? int'(sy) : int'(fy);
  endfunction

  function automatic int crgb(input bit s);
    return s ? int'({sr, sg, sb}) : int'({fr, fg, fb});
  endfunction

  task automatic start(input logic [1:0] pat);
    reset_n = 1'b0;
    pattern_sel = pat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic goto(input bit s, input int x, input int y);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(cx(s) == x && cy(s) == y) && n < 30000);
    if (!(cx(s) == x && cy(s) == y)) begin
      tests++;
      errors++;
      $display("FAIL goto: got (%0d,%0d) expected (%0d,%0d)", cx(s), cy(s), x, y);
    end
  endtask

  initial begin
    int hd_n, hs_n, ls_n, ls_at, hs_x;
    int fs_at, vs_n, vd_n, vs_x, vs_y;
    v[0]  = '{0, 2'd1,  79,  0, 6'b000000, "bars_x79"};
    v[1]  = '{0, 2'd1,  80,  0, 6'b000011, "bars_x80"};
    v[2]  = '{0, 2'd1, 320,  0, 6'b110000, "bars_x320"};
    v[3]  = '{0, 2'd1, 639,  0, 6'b111111, "bars_x639"};
    v[4]  = '{0, 2'd1, 640,  0, 6'b000000, "bars_x640"};
    v[5]  = '{0, 2'd2,  31,  0, 6'b000000, "chk_31_0"};
    v[6]  = '{0, 2'd2,  32,  0, 6'b111111, "chk_32_0"};
    v[7]  = '{0, 2'd2,  32, 32, 6'b000000, "chk_32_32"};
    v[8]  = '{0, 2'd0, 100,  0, 6'b000000, "black"};
    v[9]  = '{1, 2'd3,   0,  1, 6'b000000, "ramp_y1"};
    v[10] = '{1, 2'd3,   0,  2, 6'b010101, "ramp_y2"};
    v[11] = '{1, 2'd3,   0,  5, 6'b101010, "ramp_y5"};
    v[12] = '{1, 2'd3,   0,  7, 6'b111111, "ramp_y7"};
    v[13] = '{1, 2'd1,  15,  3, 6'b111111, "small_bars_x15"};

    reset_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_hsync", fhs, 1);
    chk("rst_vsync", fvs, 1);
    chk("rst_disp", {fhd, fvd}, 0);
    chk("rst_xy", {fx, fy}, 0);
    chk("rst_marks", {fls, ffs}, 0);
    chk("rst_rgb", crgb(0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("start_fs", ffs, 1);
    chk("start_ls", fls, 1);
    chk("start_xy", {fx, fy}, 0);
    chk("start_disp", {fhd, fvd}, 3);

    start(2'd0);
    hd_n = 0; hs_n = 0; ls_n = 0; ls_at = -1; hs_x = -1;
    for (int i = 0; i < 1600; i++) begin
      @(posedge clk);
      #1;
      hd_n += int'(fhd);
      if (!fhs) begin
        if (hs_x < 0) hs_x = int'(fx);
        hs_n++;
      end
      if (fls) begin
        if (i > 0 && ls_at < 0) ls_at = i;
        ls_n++;
      end
    end
    chk("h_display_cycles", hd_n, 1280);
    chk("hsync_low_cycles", hs_n, 192);
    chk("hsync_first_x", hs_x, 656);
    chk("line_start_count", ls_n, 2);
    chk("line_period", ls_at, 800);

    start(2'd0);
    fs_at = -1; vs_n = 0; vd_n = 0; vs_x = -1; vs_y = -1;
    for (int i = 0; i < 624; i++) begin
      @(posedge clk);
      #1;
      if (sfs && i > 0 && fs_at < 0) fs_at = i;
      if (!svs) begin
        if (vs_x < 0) begin vs_x = int'(sx); vs_y = int'(sy); end
        vs_n++;
      end
      if (!svd) vd_n++;
    end
    chk("frame_period", fs_at, 312);
    chk("vsync_low_cycles", vs_n, 96);
    chk("vsync_first_x", vs_x, 0);
    chk("vsync_first_y", vs_y, 9);
    chk("v_display_low_cycles", vd_n, 240);

    for (int i = 0; i < 14; i++) begin
      start(v[i].pat);
      goto(v[i].s, v[i].x, v[i].y);
      chk(v[i].name, crgb(v[i].s), int'(v[i].rgb));
    end

    start(2'd1);
    goto(1, 2, 4);
    chk("latch_before", crgb(1), 6'b000011);
    pattern_sel = 2'd2;
    goto(1, 2, 6);
    chk("latch_held", crgb(1), 6'b000011);
    goto(1, 2, 0);
    chk("latch_new_frame", crgb(1), 0);

    start(2'd1);
    goto(1, 3, 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_xy", {sx, sy}, 0);
    chk("midrst_sync", {shs, svs}, 3);
    chk("midrst_disp", {shd, svd, sls, sfs}, 0);
    chk("midrst_rgb", crgb(1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_fs", {sfs, sls, shd, svd}, 15);
    chk("restart_xy", {sx, sy}, 0);
    @(posedge clk);
    #1;
    chk("restart_x1", int'(sx), 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
